// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the hazard controller slice.
// Register index width follows the tracked register file size.
package ysyx_24080006_pkg;

  localparam int NREG      = 16;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int DEF_CNT_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ysyx_24080006_hazard_ctrl_if.sv
// ID/EX/WB handshake bundle seen by the hazard controller.
// master = pipeline stages, slave = controller.
interface ysyx_24080006_hazard_ctrl_if
  import ysyx_24080006_pkg::*;
  ();

  logic     id_valid;
  logic     id_rs1_en;
  reg_idx_t id_rs1;
  logic     id_rs2_en;
  reg_idx_t id_rs2;
  logic     id_rd_we;
  reg_idx_t id_rd;
  logic     id_serialize;
  logic     ex_ready;
  logic     wb_valid;
  logic     wb_we;
  reg_idx_t wb_rd;
  logic     ex_redirect;
  logic     id_stall;
  logic     issue;
  logic     flush_if;
  logic     flush_id;
  logic     sb_empty;

  modport master (
    output id_valid, id_rs1_en, id_rs1,
    output id_rs2_en, id_rs2, id_rd_we, id_rd,
    output id_serialize, ex_ready,
    output wb_valid, wb_we, wb_rd, ex_redirect,
    input  id_stall, issue, flush_if,
    input  flush_id, sb_empty
  );

  modport slave (
    input  id_valid, id_rs1_en, id_rs1,
    input  id_rs2_en, id_rs2, id_rd_we, id_rd,
    input  id_serialize, ex_ready,
    input  wb_valid, wb_we, wb_rd, ex_redirect,
    output id_stall, issue, flush_if,
    output flush_id, sb_empty
  );

endinterface

// File: rtl/ysyx_24080006_sb_cnt.sv
// Saturating up/down pending-write counter for one register.
// Simultaneous inc and dec cancel; a decrement at zero is flagged.
module ysyx_24080006_sb_cnt #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full
);

  assign zero = (cnt == '0);
  assign full = &cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        inc & ~dec & ~full: cnt <= cnt + W'(1);
        dec & ~inc & ~zero: cnt <= cnt - W'(1);
        default: ;
      endcase
    end
  end

  // A retire for a register with nothing in flight is a pipeline bug
  underflow_chk: assert property (
    @(posedge clock) disable iff (!reset)
    !(dec && !inc && zero)
  );

endmodule

// File: rtl/ysyx_24080006_hazard_ctrl.sv
// Scoreboard hazard controller: RAW/WAW-overflow/serialize stalls
// and IF/ID flush on EX redirect; WB clears are bypassed.
module ysyx_24080006_hazard_ctrl
  import ysyx_24080006_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clock,
  input logic reset,
  ysyx_24080006_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NREG-1:0]  clr;
  logic [NREG-1:0]  zero;
  logic [NREG-1:0]  full;
  logic [NREG-1:0]  eff_nz;
  logic [NREG-1:0]  eff_full;
  logic [CNT_W-1:0] cnt [NREG];
  logic raw, waw_ovf, ser, stall, go;

  assign cnt[0]  = '0;
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;

  always_comb begin
    clr = '0;
    if (hz.wb_valid && hz.wb_we && hz.wb_rd != '0)
      clr[hz.wb_rd] = 1'b1;
  end

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    ysyx_24080006_sb_cnt #(.W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (go && hz.id_rd_we &&
              hz.id_rd == reg_idx_t'(r)),
      .dec   (clr[r]),
      .cnt   (cnt[r]),
      .zero  (zero[r]),
      .full  (full[r])
    );
  end

  // Effective count: this cycle's WB retire is already visible
  always_comb begin
    eff_nz   = '0;
    eff_full = '0;
    for (int r = 0; r < NREG; r++) begin
      eff_nz[r]   = ~zero[r] &
                    ~(clr[r] & (cnt[r] == ONE));
      eff_full[r] = full[r] & ~clr[r];
    end
  end

  assign raw =
    (hz.id_rs1_en && hz.id_rs1 != '0 &&
     eff_nz[hz.id_rs1]) ||
    (hz.id_rs2_en && hz.id_rs2 != '0 &&
     eff_nz[hz.id_rs2]);

  assign waw_ovf = hz.id_rd_we && hz.id_rd != '0 &&
                   eff_full[hz.id_rd];

  assign ser   = hz.id_serialize && (|eff_nz);
  assign stall = hz.id_valid && (raw || waw_ovf || ser);
  assign go    = hz.id_valid && !stall &&
                 hz.ex_ready && !hz.ex_redirect;

  assign hz.id_stall = stall;
  assign hz.issue    = go;
  assign hz.flush_if = hz.ex_redirect;
  assign hz.flush_id = hz.ex_redirect;
  assign hz.sb_empty = &zero;

endmodule

// File: tb/tb_ysyx_24080006_hazard_ctrl.sv
// Directed scenarios then random traffic, checked against
// a per-register in-flight count model.
module tb_ysyx_24080006_hazard_ctrl;
  import ysyx_24080006_pkg::*;

  localparam int MAXC = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ysyx_24080006_hazard_ctrl_if bus ();

  ysyx_24080006_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clock = ~clock;

  int cnt_m [NREG];
  int errors = 0;
  int checks = 0;
  bit e_stall, e_issue;

  task automatic chk(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic int eff(int r);
    int e;
    e = cnt_m[r];
    if (r != 0 && bus.wb_valid && bus.wb_we &&
        int'(bus.wb_rd) == r && e > 0)
      e = e - 1;
    return e;
  endfunction

  task automatic model_check(string tag);
    bit raw, waw, ser, empty;
    int s1, s2, d;
    s1 = int'(bus.id_rs1);
    s2 = int'(bus.id_rs2);
    d  = int'(bus.id_rd);
    raw = (bus.id_rs1_en && s1 != 0 && eff(s1) != 0) ||
          (bus.id_rs2_en && s2 != 0 && eff(s2) != 0);
    waw = bus.id_rd_we && d != 0 && eff(d) == MAXC;
    ser = 1'b0;
    empty = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      if (eff(r) != 0) ser = 1'b1;
      if (cnt_m[r] != 0) empty = 1'b0;
    end
    ser = ser && bus.id_serialize;
    e_stall = bus.id_valid && (raw || waw || ser);
    e_issue = bus.id_valid && !e_stall &&
              bus.ex_ready && !bus.ex_redirect;
    chk({tag, ".stall"}, bus.id_stall, e_stall);
    chk({tag, ".issue"}, bus.issue, e_issue);
    chk({tag, ".flush_if"}, bus.flush_if, bus.ex_redirect);
    chk({tag, ".flush_id"}, bus.flush_id, bus.ex_redirect);
    chk({tag, ".empty"}, bus.sb_empty, empty);
  endtask

  task automatic model_update();
    int d, w;
    d = int'(bus.id_rd);
    w = int'(bus.wb_rd);
    if (!reset) return;
    if (e_issue && bus.id_rd_we && d != 0)
      cnt_m[d] = cnt_m[d] + 1;
    if (bus.wb_valid && bus.wb_we && w != 0 && cnt_m[w] > 0)
      cnt_m[w] = cnt_m[w] - 1;
  endtask

  // One cycle: check combinational outputs, then clock the model.
  task automatic cyc(string tag, int xs = -1, int xi = -1);
    #1 model_check(tag);
    if (xs >= 0) chk({tag, ".dir_stall"}, bus.id_stall, xs != 0);
    if (xi >= 0) chk({tag, ".dir_issue"}, bus.issue, xi != 0);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.id_valid     = 1'b0;
    bus.id_rs1_en    = 1'b0;
    bus.id_rs1       = '0;
    bus.id_rs2_en    = 1'b0;
    bus.id_rs2       = '0;
    bus.id_rd_we     = 1'b0;
    bus.id_rd        = '0;
    bus.id_serialize = 1'b0;
    bus.ex_ready     = 1'b1;
    bus.wb_valid     = 1'b0;
    bus.wb_we        = 1'b0;
    bus.wb_rd        = '0;
    bus.ex_redirect  = 1'b0;
  endtask

  task automatic id_op(int rs1, int rs2, int rd, bit ser = 0);
    bus.id_valid     = 1'b1;
    bus.id_rs1_en    = rs1 >= 0;
    bus.id_rs1       = reg_idx_t'(rs1 < 0 ? 0 : rs1);
    bus.id_rs2_en    = rs2 >= 0;
    bus.id_rs2       = reg_idx_t'(rs2 < 0 ? 0 : rs2);
    bus.id_rd_we     = rd >= 0;
    bus.id_rd        = reg_idx_t'(rd < 0 ? 0 : rd);
    bus.id_serialize = ser;
  endtask

  task automatic wb(int rd);
    bus.wb_valid = 1'b1;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = reg_idx_t'(rd);
  endtask

  initial begin
    int r;
    for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
    idle();
    #2;
    chk("rst.empty", bus.sb_empty, 1'b1);
    chk("rst.stall", bus.id_stall, 1'b0);
    chk("rst.issue", bus.issue, 1'b0);
    chk("rst.flush_if", bus.flush_if, 1'b0);
    chk("rst.flush_id", bus.flush_id, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // RAW on x5 held until WB of x5, then issue in that cycle
    id_op(-1, -1, 5);      cyc("raw.prod", 0, 1);
    id_op(5, -1, 6);       cyc("raw.wait0", 1, 0);
    cyc("raw.wait1", 1, 0);
    wb(5);                 cyc("raw.bypass", 0, 1);
    idle(); wb(6);         cyc("raw.drain");
    idle();                cyc("raw.idle");
    chk("raw.empty", bus.sb_empty, 1'b1);

    // x0 is never tracked
    id_op(0, 0, 0);        cyc("x0.rd0", 0, 1);
    idle();
    chk("x0.empty", bus.sb_empty, 1'b1);
    id_op(-1, -1, 9);      cyc("x0.set9", 0, 1);
    id_op(0, 0, 0);        cyc("x0.rs0", 0, 1);
    idle(); wb(9);         cyc("x0.clr9");
    idle();                cyc("x0.idle");

    // WAW saturation on x3
    id_op(-1, -1, 3);      cyc("waw.i1", 0, 1);
    id_op(-1, -1, 3);      cyc("waw.i2", 0, 1);
    id_op(-1, -1, 3);      cyc("waw.i3", 0, 1);
    id_op(-1, -1, 3);      cyc("waw.ovf", 1, 0);
    id_op(7, -1, -1);      cyc("waw.x7", 0, 1);
    idle(); wb(3);         cyc("waw.d1");
    wb(3);                 cyc("waw.d2");
    wb(3);                 cyc("waw.d3");
    idle();                cyc("waw.idle");
    chk("waw.empty", bus.sb_empty, 1'b1);

    // Simultaneous inc and dec on x4
    id_op(-1, -1, 4);      cyc("same.i1", 0, 1);
    id_op(-1, -1, 4); wb(4); cyc("same.both", 0, 1);
    idle();
    chk("same.nonempty", bus.sb_empty, 1'b0);
    wb(4);                 cyc("same.d");
    idle();
    chk("same.empty", bus.sb_empty, 1'b1);

    // Serialize against x6, then redirect leaves counters alone
    id_op(-1, -1, 6);      cyc("ser.i6", 0, 1);
    id_op(-1, -1, -1, 1);  cyc("ser.wait", 1, 0);
    wb(6);                 cyc("ser.bypass", 0, 1);
    idle(); id_op(-1, -1, 6); cyc("red.i6", 0, 1);
    id_op(-1, -1, 6); bus.ex_redirect = 1'b1;
    cyc("red.flush", 0, 0);
    idle();
    chk("red.nonempty", bus.sb_empty, 1'b0);
    wb(6);                 cyc("red.d");
    idle();
    chk("red.empty", bus.sb_empty, 1'b1);

    // Asynchronous reset with x2 at two in flight
    id_op(-1, -1, 2);      cyc("rst2.i1", 0, 1);
    id_op(-1, -1, 2);      cyc("rst2.i2", 0, 1);
    id_op(2, -1, -1);
    #1 chk("rst2.pre_stall", bus.id_stall, 1'b1);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
    chk("rst2.empty", bus.sb_empty, 1'b1);
    chk("rst2.stall", bus.id_stall, 1'b0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    cyc("rst2.after");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.id_valid     = $urandom_range(0, 3) != 0;
      bus.id_rs1_en    = $urandom_range(0, 1);
      bus.id_rs1       = reg_idx_t'($urandom_range(0, 6));
      bus.id_rs2_en    = $urandom_range(0, 1);
      bus.id_rs2       = reg_idx_t'($urandom_range(0, 6));
      bus.id_rd_we     = $urandom_range(0, 3) != 0;
      bus.id_rd        = reg_idx_t'($urandom_range(0, 6));
      bus.id_serialize = $urandom_range(0, 7) == 0;
      bus.ex_ready     = $urandom_range(0, 3) != 0;
      bus.ex_redirect  = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 1) == 1) begin
        bus.wb_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
          r = $urandom_range(1, 6);
          if (cnt_m[r] > 0) begin
            bus.wb_we = 1'b1;
            bus.wb_rd = reg_idx_t'(r);
            break;
          end
        end
      end
      cyc($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
